// File: rtl/chip_load_pkg.sv
// Shared load-path definitions: sequencer state encoding, default region
// lengths and region index constants for the CNN / FC / image memories.
package chip_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_LOAD = 2'd2,
    ST_FIN  = 2'd3
  } load_state_t;

  localparam int unsigned CNN_WORDS = 50704;
  localparam int unsigned FC_WORDS  = 11218;
  localparam int unsigned IMG_WORDS = 1024;

  localparam int unsigned REG_CNN = 0;
  localparam int unsigned REG_FC  = 1;
  localparam int unsigned REG_IMG = 2;

endpackage

// File: rtl/weight_load_sequencer_if.sv
// Stream-in and memory write-out bus of the weight load sequencer.
// slave = the sequencer; master = the IO loader / memory side.
interface weight_load_sequencer_if #(
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16
);
  logic [DATA_W-1:0]      s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [NUM_REGIONS-1:0] mem_sel;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_we;

  modport master (
    output s_data, s_valid,
    input  s_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, mem_sel, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_region_select.sv
// Lowest-index priority pick over the pending-region mask.
module load_region_select #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] i_pending,
  output logic [N-1:0] o_onehot,
  output logic         o_none
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_pending & (~i_pending + 1'b1);
  assign o_none   = ~|i_pending;

endmodule

// File: rtl/weight_load_sequencer.sv
// Streams IO words into up to NUM_REGIONS memories in index order over one
// write bus. Define LOAD_CHECKSUM_EN to build the accepted-word checksum.
module weight_load_sequencer
  import chip_load_pkg::*;
#(
  parameter int unsigned                   NUM_REGIONS = 3,
  parameter int unsigned                   DATA_W      = 16,
  parameter int unsigned                   ADDR_W      = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN  =
    {16'(IMG_WORDS), 16'(FC_WORDS), 16'(CNN_WORDS)}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [NUM_REGIONS-1:0] region_mask,
  weight_load_sequencer_if.slave bus,
  output logic                   busy,
  output logic [NUM_REGIONS-1:0] region_done,
  output logic                   done,
  output logic [DATA_W-1:0]      checksum
);

  load_state_t r_state, w_next;

  logic [NUM_REGIONS-1:0] w_len_nz;
  logic [NUM_REGIONS-1:0] w_eff_mask;
  logic [NUM_REGIONS-1:0] w_pick;
  logic                   w_none;
  logic [ADDR_W-1:0]      w_pick_len;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_start;

  logic [NUM_REGIONS-1:0] r_pending;
  logic [ADDR_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]      r_len;
  logic [NUM_REGIONS-1:0] r_mem_sel;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic                   r_mem_we;
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_REGIONS-1:0] r_region_done;

  always_comb begin
    w_len_nz   = '0;
    w_pick_len = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      w_len_nz[i] = |REGION_LEN[i*ADDR_W +: ADDR_W];
      if (w_pick[i]) w_pick_len = w_pick_len | REGION_LEN[i*ADDR_W +: ADDR_W];
    end
  end

  // Zero-length regions are dropped up front so SEL never enters an empty LOAD.
  assign w_eff_mask = region_mask & w_len_nz;
  assign w_start    = (r_state == ST_IDLE) && load;
  assign w_accept   = w_s_ready && bus.s_valid;
  assign w_last     = (r_cnt == r_len - 1'b1);

  load_region_select #(.N(NUM_REGIONS)) u_select (
    .i_pending (r_pending),
    .o_onehot  (w_pick),
    .o_none    (w_none)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    case (r_state)
      ST_IDLE: if (load) w_next = (w_eff_mask == '0) ? ST_FIN : ST_SEL;
      ST_SEL:  w_next = w_none ? ST_FIN : ST_LOAD;
      ST_LOAD: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && w_last) w_next = ST_SEL;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_cnt         <= '0;
      r_len         <= '0;
      r_mem_sel     <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_region_done <= '0;
    end else begin
      r_mem_we <= w_accept;
      r_done   <= (r_state == ST_FIN);

      if (w_start) begin
        r_busy        <= 1'b1;
        r_region_done <= '0;
        r_pending     <= w_eff_mask;
      end else if (r_state == ST_FIN) begin
        r_busy <= 1'b0;
      end

      if (r_state == ST_SEL) begin
        r_cnt <= '0;
        if (!w_none) begin
          r_mem_sel <= w_pick;
          r_len     <= w_pick_len;
          r_pending <= r_pending & ~w_pick;
        end
      end

      // Completion flag lands with the final write, one cycle after acceptance.
      if (w_accept) begin
        r_mem_addr  <= r_cnt;
        r_mem_wdata <= bus.s_data;
        r_cnt       <= r_cnt + 1'b1;
        if (w_last) r_region_done <= r_region_done | r_mem_sel;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst)           r_checksum <= '0;
    else if (w_start)  r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum + bus.s_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign bus.s_ready   = w_s_ready;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign busy          = r_busy;
  assign done          = r_done;
  assign region_done   = r_region_done;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed table-driven bench for weight_load_sequencer with region lengths 4/3/2.
module tb_weight_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [2:0]  region_mask;
  logic        busy;
  logic [2:0]  region_done;
  logic        done;
  logic [15:0] checksum;

  weight_load_sequencer_if #(.NUM_REGIONS(3), .DATA_W(16), .ADDR_W(16)) bus ();

  weight_load_sequencer #(
    .NUM_REGIONS (3),
    .DATA_W      (16),
    .ADDR_W      (16),
    .REGION_LEN  ({16'd2, 16'd3, 16'd4})
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .region_mask (region_mask),
    .bus         (bus),
    .busy        (busy),
    .region_done (region_done),
    .done        (done),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]  mask;
    bit          toggle;
    int          relo_k;
    int          exp_writes;
    logic [2:0]  exp_rdone;
    int          exp_lat;
    logic [15:0] exp_sum;
  } vec_t;

  int   LEN[3] = '{4, 3, 2};
  wr_t  wlog[$];
  int   cyc       = 0;
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  logic done_busy = 1'b0;
  int   n_vec     = 0;
  int   n_bad     = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we) wlog.push_back('{bus.mem_sel, bus.mem_addr, bus.mem_wdata});
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input bit vld);
    bit acc;
    bus.s_valid = vld;
    @(negedge clk);
    acc = bus.s_valid && bus.s_ready;
    @(posedge clk);
    #1;
    if (acc) bus.s_data = bus.s_data + 16'd1;
  endtask

  task automatic run_vec(input vec_t v);
    wr_t         exp_q[$];
    int          d;
    int          L;
    int          k;
    int          start_done;
    int          n;
    logic [15:0] exp_sum;
    d = 1;
    for (int i = 0; i < 3; i++)
      if (v.mask[i])
        for (int a = 0; a < LEN[i]; a++) begin
          exp_q.push_back('{3'(1 << i), 16'(a), 16'(d)});
          d++;
        end
`ifdef LOAD_CHECKSUM_EN
    exp_sum = v.exp_sum;
`else
    exp_sum = 16'd0;
`endif
    wlog.delete();
    start_done  = done_cnt;
    L           = cyc + 1;
    bus.s_data  = 16'd1;
    region_mask = v.mask;
    k = 0;
    while (done_cnt == start_done && k < 300) begin
      load = (k == 0) || (k == v.relo_k);
      if (k == v.relo_k) region_mask = 3'b010;
      drive_cycle(v.toggle ? (k % 2 == 0) : 1'b1);
      k++;
    end
    load        = 1'b0;
    region_mask = v.mask;
    chk("done_seen", 32'(done_cnt != start_done), 32'd1);
    for (int j = 0; j < 3; j++) drive_cycle(1'b0);
    chk("write_count", 32'(wlog.size()), 32'(exp_q.size()));
    n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      chk("wr_sel",  32'(wlog[j].sel),  32'(exp_q[j].sel));
      chk("wr_addr", 32'(wlog[j].addr), 32'(exp_q[j].addr));
      chk("wr_data", 32'(wlog[j].data), 32'(exp_q[j].data));
    end
    chk("done_pulses",  32'(done_cnt - start_done), 32'd1);
    chk("done_latency", 32'(done_cyc - L),          32'(v.exp_lat));
    chk("busy_at_done", 32'(done_busy),             32'd0);
    chk("region_done",  32'(region_done),           32'(v.exp_rdone));
    chk("checksum",     32'(checksum),              32'(exp_sum));
    chk("busy_after",   32'(busy),                  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   k;
    vt[0] = '{3'b111, 1'b0, -1, 9, 3'b111, 15, 16'd45};
    vt[1] = '{3'b101, 1'b0, -1, 6, 3'b101, 11, 16'd21};
    vt[2] = '{3'b000, 1'b0, -1, 0, 3'b000,  2, 16'd0};
    vt[3] = '{3'b001, 1'b1, -1, 4, 3'b001, 11, 16'd10};
    vt[4] = '{3'b111, 1'b0,  8, 9, 3'b111, 15, 16'd45};
    vt[5] = '{3'b010, 1'b0, -1, 3, 3'b010,  7, 16'd6};

    rst         = 1'b1;
    load        = 1'b0;
    region_mask = 3'b000;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",        32'(busy),          32'd0);
    chk("rst_done",        32'(done),          32'd0);
    chk("rst_region_done", 32'(region_done),   32'd0);
    chk("rst_mem_we",      32'(bus.mem_we),    32'd0);
    chk("rst_mem_sel",     32'(bus.mem_sel),   32'd0);
    chk("rst_mem_addr",    32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata",   32'(bus.mem_wdata), 32'd0);
    chk("rst_s_ready",     32'(bus.s_ready),   32'd0);
    chk("rst_checksum",    32'(checksum),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle(1'b0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Reset after the second region-1 write, then a clean restart.
    wlog.delete();
    region_mask = 3'b111;
    bus.s_data  = 16'd1;
    load        = 1'b1;
    drive_cycle(1'b1);
    load = 1'b0;
    k = 0;
    while (wlog.size() < 6 && k < 100) begin
      drive_cycle(1'b1);
      k++;
    end
    chk("rst_seq_reached", 32'(wlog.size()), 32'd6);
    rst = 1'b1;
    drive_cycle(1'b1);
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy",        32'(busy),        32'd0);
    chk("abort_mem_we",      32'(bus.mem_we),  32'd0);
    chk("abort_region_done", 32'(region_done), 32'd0);
    chk("abort_done",        32'(done),        32'd0);
    chk("abort_checksum",    32'(checksum),    32'd0);
    chk("abort_write_count", 32'(wlog.size()), 32'd7);
    @(posedge clk);
    #1;
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
